// File: rtl/pulse_wave_gen.sv
// pulse_wave_gen: square/pulse generator driven by an external phase stream.
// Threshold and high/low levels are written into a pending set. The pending
// set is copied into the active set only at phase wrap, so a period is never
// altered partway through.
// Optional feature: define PULSE_WAVE_SLEW_EN to limit how far the output
// moves per valid sample (SLEW_STEP).
module pulse_wave_gen #(
  parameter int DW        = 12,
  parameter int PW        = 8,
  parameter int DEF_AMP   = 1000,
  parameter int SLEW_STEP = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phase_valid,
  input  logic [PW-1:0]        phase,
  input  logic                 cfg_we,
  input  logic [PW-1:0]        cfg_thresh,
  input  logic signed [DW-1:0] cfg_high,
  input  logic signed [DW-1:0] cfg_low,
  output logic signed [DW-1:0] wave,
  output logic                 wave_valid,
  output logic                 cycle_start,
  output logic                 cfg_pending
);

  localparam logic [PW-1:0]        DEF_THRESH = {1'b1, {(PW-1){1'b0}}};
  localparam logic signed [DW-1:0] DEF_HIGH   = DW'(DEF_AMP);
  localparam logic signed [DW-1:0] DEF_LOW    = DW'(-DEF_AMP);

  // A non-positive step is meaningless; no logic is built for that case.
  if (SLEW_STEP <= 0) begin : g_slew_step_invalid
  end

  logic [PW-1:0]        pend_thresh, act_thresh;
  logic signed [DW-1:0] pend_high, act_high;
  logic signed [DW-1:0] pend_low, act_low;
  logic [PW-1:0]        prev_phase;
  logic                 first;

  logic                 wrap;
  logic [PW-1:0]        sel_thresh;
  logic signed [DW-1:0] sel_high, sel_low;
  logic signed [DW-1:0] target;
  logic signed [DW-1:0] next_wave;

  // A period starts on the first valid sample or when the phase goes backwards.
  assign wrap = phase_valid && (first || (phase < prev_phase));

  // The sample that wraps already uses the set being transferred.
  always_comb begin
    sel_thresh = wrap ? pend_thresh : act_thresh;
    sel_high   = wrap ? pend_high   : act_high;
    sel_low    = wrap ? pend_low    : act_low;
    target     = (phase >= sel_thresh) ? sel_high : sel_low;
  end

`ifdef PULSE_WAVE_SLEW_EN
  localparam logic signed [DW:0] STEP = (DW+1)'(SLEW_STEP);
  logic signed [DW:0] diff;

  // Move toward the target by at most STEP, landing exactly on the target.
  always_comb begin
    diff = {target[DW-1], target} - {wave[DW-1], wave};
    if (diff > STEP) begin
      next_wave = wave + STEP[DW-1:0];
    end else if (diff < -STEP) begin
      next_wave = wave - STEP[DW-1:0];
    end else begin
      next_wave = target;
    end
  end
`else
  // The output jumps straight to the selected level.
  always_comb begin
    next_wave = target;
  end
`endif

  // Pending set: loaded by every configuration write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_thresh <= DEF_THRESH;
      pend_high   <= DEF_HIGH;
      pend_low    <= DEF_LOW;
    end else if (cfg_we) begin
      pend_thresh <= cfg_thresh;
      pend_high   <= cfg_high;
      pend_low    <= cfg_low;
    end
  end

  // Active set: takes the previously pending values at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_thresh <= DEF_THRESH;
      act_high   <= DEF_HIGH;
      act_low    <= DEF_LOW;
    end else if (wrap) begin
      act_thresh <= pend_thresh;
      act_high   <= pend_high;
      act_low    <= pend_low;
    end
  end

  // Wrap detection compares against the last valid phase, ignoring gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_phase <= '0;
      first      <= 1'b1;
    end else if (phase_valid) begin
      prev_phase <= phase;
      first      <= 1'b0;
    end
  end

  // Registered sample outputs; wave holds between valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave        <= '0;
      wave_valid  <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      wave_valid  <= phase_valid;
      cycle_start <= wrap;
      if (phase_valid) begin
        wave <= next_wave;
      end
    end
  end

  // A write marks the pending set. A wrap clears the mark unless a write arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pending <= 1'b0;
    end else if (cfg_we) begin
      cfg_pending <= 1'b1;
    end else if (wrap) begin
      cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_wave_gen.sv
// tb_pulse_wave_gen: scoreboard bench for pulse_wave_gen.
// Stimulus pushes expected samples from a behavioural model.
// A monitor pops an expected sample whenever wave_valid is seen.
module tb_pulse_wave_gen;

  localparam int DW        = 12;
  localparam int PW        = 8;
  localparam int DEF_AMP   = 1000;
  localparam int SLEW_STEP = 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 phase_valid = 1'b0;
  logic [PW-1:0]        phase = '0;
  logic                 cfg_we = 1'b0;
  logic [PW-1:0]        cfg_thresh = '0;
  logic signed [DW-1:0] cfg_high = '0;
  logic signed [DW-1:0] cfg_low = '0;
  logic signed [DW-1:0] wave;
  logic                 wave_valid;
  logic                 cycle_start;
  logic                 cfg_pending;

  pulse_wave_gen #(
    .DW(DW), .PW(PW), .DEF_AMP(DEF_AMP), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .phase_valid(phase_valid), .phase(phase),
    .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
    .cfg_high(cfg_high), .cfg_low(cfg_low),
    .wave(wave), .wave_valid(wave_valid),
    .cycle_start(cycle_start), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wave;
    bit cs;
    bit pend;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   in_reset = 1'b1;
  int   hold_wave = 0;
  bit   hold_pend = 1'b0;

  // Reference model state: the pending and active settings plus the phase history.
  int m_pth, m_phi, m_plo, m_ath, m_ahi, m_alo, m_prev, m_wave;
  bit m_first, m_pend;

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pth = 1 << (PW-1); m_phi = DEF_AMP; m_plo = -DEF_AMP;
    m_ath = 1 << (PW-1); m_ahi = DEF_AMP; m_alo = -DEF_AMP;
    m_prev = 0; m_first = 1'b1; m_pend = 1'b0; m_wave = 0;
  endtask

  // Drive one cycle and enqueue what the generator should show one clock later.
  task automatic applyStimulus(input bit v, input int ph, input bit we,
                               input int th, input int hi, input int lo);
    bit wrap;
    int target;
    int diff;
    @(negedge clk);
    phase_valid = v;
    phase       = PW'(ph);
    cfg_we      = we && v;
    cfg_thresh  = PW'(th);
    cfg_high    = DW'(hi);
    cfg_low     = DW'(lo);
    if (v) begin
      wrap = m_first || (ph < m_prev);
      if (wrap) begin
        m_ath = m_pth; m_ahi = m_phi; m_alo = m_plo;
      end
      if (we) begin
        m_pth = th; m_phi = hi; m_plo = lo; m_pend = 1'b1;
      end else if (wrap) begin
        m_pend = 1'b0;
      end
      target = (ph >= m_ath) ? m_ahi : m_alo;
`ifdef PULSE_WAVE_SLEW_EN
      diff = target - m_wave;
      if (diff > SLEW_STEP)       m_wave = m_wave + SLEW_STEP;
      else if (diff < -SLEW_STEP) m_wave = m_wave - SLEW_STEP;
      else                        m_wave = target;
`else
      diff   = 0;
      m_wave = target + diff;
`endif
      m_prev  = ph;
      m_first = 1'b0;
      sb.push_back('{m_wave, wrap, m_pend});
    end
  endtask

  task automatic sweep(input int thr_write_at, input int th, input int hi, input int lo);
    for (int p = 0; p < 256; p++) begin
      applyStimulus(1'b1, p, (p == thr_write_at), th, hi, lo);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    in_reset    = 1'b1;
    rst_n       = 1'b0;
    phase_valid = 1'b0;
    cfg_we      = 1'b0;
    #1;
    checkOutput("rst_wave", int'(wave), 0);
    checkOutput("rst_wave_valid", int'(wave_valid), 0);
    checkOutput("rst_cycle_start", int'(cycle_start), 0);
    checkOutput("rst_cfg_pending", int'(cfg_pending), 0);
    sb.delete();
    modelReset();
    hold_wave = 0;
    hold_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: pop on every presented sample, otherwise require the output to hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (wave_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_sample: got wave_valid=1 expected no sample at %0t", $time);
          end else begin
            mon_e = sb.pop_front();
            checkOutput("wave", int'(wave), mon_e.wave);
            checkOutput("cycle_start", int'(cycle_start), int'(mon_e.cs));
            checkOutput("cfg_pending", int'(cfg_pending), int'(mon_e.pend));
            hold_wave = mon_e.wave;
            hold_pend = mon_e.pend;
          end
        end else begin
          checkOutput("hold_wave", int'(wave), hold_wave);
          checkOutput("idle_cycle_start", int'(cycle_start), 0);
          checkOutput("idle_cfg_pending", int'(cfg_pending), int'(hold_pend));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ph;
    bit v;
    bit we;
    int hi;
    int lo;
    modelReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("init_wave", int'(wave), 0);
    checkOutput("init_wave_valid", int'(wave_valid), 0);
    checkOutput("init_cycle_start", int'(cycle_start), 0);
    checkOutput("init_cfg_pending", int'(cfg_pending), 0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;

    $display("[TB] default sweep");
    sweep(-1, 0, 0, 0);

    $display("[TB] mid-period configuration write");
    sweep(30, 64, 500, -200);
    sweep(-1, 0, 0, 0);

    $display("[TB] write coincident with wrap");
    sweep(0, 200, 700, -700);
    sweep(-1, 0, 0, 0);

    $display("[TB] valid gaps");
    applyStimulus(1'b1, 250, 1'b0, 0, 0, 0);
    repeat (5) applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 3, 1'b0, 0, 0, 0);

    $display("[TB] randomized traffic");
    ph = 3;
    repeat (800) begin
      v  = ($urandom % 10) < 7;
      if (v) ph = (ph + 1 + int'($urandom % 8)) % 256;
      we = v && (($urandom % 20) == 0);
      hi = int'($urandom_range(0, 4000)) - 2000;
      lo = (($urandom % 4) == 0) ? hi : int'($urandom_range(0, 4000)) - 2000;
      applyStimulus(v, ph, we, int'($urandom % 256), hi, lo);
    end

    $display("[TB] reset after reprogram");
    applyStimulus(1'b1, 10, 1'b1, 20, 300, -300);
    for (int p = 11; p < 60; p++) applyStimulus(1'b1, p, 1'b0, 0, 0, 0);
    for (int p = 0; p < 40; p++) applyStimulus(1'b1, p, 1'b0, 0, 0, 0);
    doReset();
    sweep(-1, 0, 0, 0);

    repeat (3) applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_wave_gen.md
# pulse_wave_gen

Parametrised square/pulse waveform generator. It consumes a phase stream from the shared phase accumulator and produces a signed sample stream for the oscilloscope display and mixer path. The threshold (duty) and the high/low levels are runtime-programmable through shadow registers that take effect only at phase wrap, so the output never glitches mid-period. Optional slew limiting softens edges.

## Interface
- `DW`, default 12: output sample width, signed.
- `PW`, default 8: phase width.
- `DEF_AMP`, default 1000: reset value of the high level; the low level resets to `-DEF_AMP`.
- `SLEW_STEP`, default 64: maximum change of `wave` per valid sample when slew limiting is compiled in. Must be greater than 0.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `phase_valid`, input, 1: `phase` carries a new sample this cycle.
- `phase`, input, PW: unsigned phase.
- `cfg_we`, input, 1: write the pending configuration registers.
- `cfg_thresh`, input, PW: switching threshold.
- `cfg_high`, input, DW signed: level used when `phase >= thresh`.
- `cfg_low`, input, DW signed: level used when `phase < thresh`.
- `wave`, output, DW signed: output sample.
- `wave_valid`, output, 1: `wave` was updated this cycle.
- `cycle_start`, output, 1: the sample on `wave` is the first sample of a new period.
- `cfg_pending`, output, 1: a written configuration is waiting for the next wrap.

## Operation
- **Register sets.** Two sets exist, pending and active, each holding thresh, high and low.
- **Reset values.** Both sets reset to thresh = 2^(PW-1), high = `DEF_AMP`, low = `-DEF_AMP`. Outputs reset to `wave` = 0, `wave_valid` = 0, `cycle_start` = 0, `cfg_pending` = 0. Internal state resets to `prev_phase` = 0 and `first` = 1.
- **Configuration write.** `cfg_we` loads the pending set and sets `cfg_pending`. A write mid-period has no effect on the active set.
- **Wrap event.** A wrap occurs when `phase_valid` is high and either `phase < prev_phase` or `first` = 1. `prev_phase` updates on every valid sample. `first` clears on the first valid sample.
- **Config transfer on wrap.** On a wrap, active <= pending, as registered before this cycle's write. `cfg_pending` clears, unless `cfg_we` is high in the same cycle. In that case the new values stay pending and `cfg_pending` stays 1 until the following wrap.
- **Level selection.** The sample that causes a wrap is evaluated with the newly transferred active set. The target is `(phase >= thresh) ? high : low`.
  - thresh = 0 gives a constant high level.
  - For a constant low level, program high = low.
- **Output update.** On a valid sample, `wave` <= target and `wave_valid` <= 1. `cycle_start` <= wrap.
- **No valid sample.** With no valid sample, `wave` holds its value and `wave_valid` and `cycle_start` are 0.
- **Gaps.** Gaps in `phase_valid` do not affect wrap detection: the comparison is always against the last valid phase.
- **Defaults.** Default settings reproduce the legacy square output: `-DEF_AMP` for phase below 128, `+DEF_AMP` at 128 and above (PW = 8).

## Timing
- Latency from `phase` to `wave` is 1 clock, registered. `wave_valid` and `cycle_start` are aligned with `wave`.
- Full throughput: one sample per clock.
- A `cfg_we` in cycle N makes `cfg_pending` 1 in cycle N+1.
- A wrap in cycle N makes `cfg_pending` 0 in cycle N+1, unless `cfg_we` is also high in cycle N.
- Asynchronous reset mid-period immediately forces all outputs and both register sets to reset values. The first valid sample after release is a wrap.

## Configuration
- **`PULSE_WAVE_SLEW_EN` defined.** On each valid sample, `wave` moves toward the target by at most `SLEW_STEP`.
  - Compute diff = target − `wave` in DW+1 bits signed.
  - If |diff| <= `SLEW_STEP`, `wave` <= target.
  - Otherwise `wave` <= `wave` ± `SLEW_STEP`.
  - No overflow or wrap is permitted.
  - `wave_valid` and `cycle_start` timing is unchanged.
- **Not defined.** `wave` <= target directly. No slew logic is synthesised.

## Test plan
- **Default sweep.** Reset, then sweep phase 0..255 with one valid sample per cycle. Required: `wave` = -1000 for phase 0..127 and +1000 for 128..255, each 1 cycle later. `cycle_start` = 1 only for the phase 0 sample and for each later 255→0 wrap.
- **Mid-cycle configuration.** At phase 30, write thresh = 64, high = 500, low = -200. Required: the current period is unchanged (switching at 128, ±1000) and `cfg_pending` = 1. After the 255→0 wrap, phase 0..63 gives -200 and 64..255 gives 500, and `cfg_pending` returns to 0.
- **Write coincident with wrap.** Assert `cfg_we` (thresh = 200) on the same cycle as the phase 0 sample. Required: that period still uses the previous pending set, `cfg_pending` stays 1, and thresh = 200 applies from the next wrap.
- **Valid gaps.** Drive phase 250 valid, then 5 idle cycles, then phase 3 valid. Required: `wave` holds and `wave_valid` = 0 during the gap. The phase 3 sample shows `cycle_start` = 1.
- **Slew limiting.** With `PULSE_WAVE_SLEW_EN` and `SLEW_STEP` = 64, sweep from default. Required: at phase 128 `wave` steps -936, -872, …, reaching +1000 exactly on the 32nd valid sample, with the last step clamped. The same behaviour applies on the falling edge.
- **Reset mid-operation.** Assert `rst_n` low mid-sweep after a reprogram. Required: `wave` is 0 immediately and the defaults are restored. The first valid sample after release gives `cycle_start` = 1 and ±1000 levels.
